// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch controller.
//   fetch_state_e : controller state encoding (S_IDLE, S_WAIT, S_HOLD)
//   INSTR_BYTES   : bytes per instruction word
//   PC_INC        : pc step between sequential fetches
//   CNT_W         : width of the settle counter (holds 0..15)
//   misaligned()  : true when a byte address is not word aligned
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    localparam int PC_INC      = INSTR_BYTES;
    localparam int CNT_W       = 4;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with a registered head.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : discard all entries (head data register holds its value)
//   push/wdata : write one entry (accepted when not full, or full with pop)
//   pop        : consume the head entry (ignored when empty)
//   rdata      : registered head entry, holds last value while empty
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_nxt;
    logic [COUNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]   head_nxt;
    logic               do_push;
    logic               do_pop;

    assign full  = (count == COUNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_nxt   = rd_ptr + PTR_W'(do_pop);
        cnt_nxt  = count + COUNT_W'(do_push) - COUNT_W'(do_pop);
        head_nxt = rdata;
        // The head register is loaded with whatever entry will sit at the
        // read pointer after this edge. When the FIFO drains to nothing in
        // this cycle and is refilled at once, that entry is still on wdata.
        if (cnt_nxt != '0) begin
            if (do_push && (count == COUNT_W'(do_pop)))
                head_nxt = wdata;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            count  <= cnt_nxt;
            rdata  <= head_nxt;
        end
    end

    // Storage carries data only; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the pc, drives the instruction memory address,
// waits WAIT_CYCLES settle cycles per address, captures {pc, instruction}
// into a prefetch FIFO and presents it to decode over valid/ready.
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : fetch permitted; low freezes fetch progress
//   imem_addr      : memory ReadAddress, always the pc register
//   imem_instr     : memory Instruction data
//   redirect       : branch/jump taken; flushes and reloads the pc
//   redirect_pc    : new fetch target (low two bits are dropped)
//   out_valid      : FIFO head valid
//   out_ready      : decode accepts the head
//   out_instr      : head instruction
//   out_pc         : head pc
//   busy           : controller is not idle
//   align_err      : sticky, a redirect target was not word aligned
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                WAIT_CYCLES = 1,
    parameter int                FIFO_DEPTH  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               busy,
    output logic               align_err
);

    localparam int               ENT_W     = ADDR_W + INSTR_W;
    localparam int               FCNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    fetch_state_e       state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               align_err_nxt;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]   fifo_head;

    assign imem_addr = pc;
    assign busy      = (state != S_IDLE);
    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_head[ENT_W-1 -: ADDR_W];
    assign out_instr = fifo_head[INSTR_W-1:0];

    // A handshake coinciding with a redirect is void: decode drops it and
    // the flush discards the entry anyway.
    assign fifo_pop = out_valid && out_ready && !redirect;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cnt_nxt       = cnt;
        align_err_nxt = align_err;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;

        if (redirect) begin
            fifo_flush = 1'b1;
            pc_nxt     = {redirect_pc[ADDR_W-1:2], 2'b00};
            cnt_nxt    = WAIT_LOAD;
            state_nxt  = enable ? S_WAIT : S_IDLE;
            if (misaligned(redirect_pc[1:0]))
                align_err_nxt = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (enable) begin
                        if (cnt != '0) begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end else if (!fifo_full) begin
                            fifo_push = 1'b1;
                            pc_nxt    = pc + ADDR_W'(PC_INC);
                            cnt_nxt   = WAIT_LOAD;
                        end else begin
                            state_nxt = S_HOLD;
                        end
                    end else if (cnt == WAIT_LOAD) begin
                        // Nothing spent on this pc yet, so parking is free.
                        state_nxt = S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Space includes a pop landing on the same edge as the push.
                    if (enable && ((fifo_count != FCNT_W'(FIFO_DEPTH)) || fifo_pop)) begin
                        fifo_push = 1'b1;
                        pc_nxt    = pc + ADDR_W'(PC_INC);
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = S_WAIT;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            cnt       <= '0;
            align_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cnt       <= cnt_nxt;
            align_err <= align_err_nxt;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata ({pc, imem_instr}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scoreboard bench for instr_fetch_ctrl.
// Stimulus queues the expected {pc, instr} stream; a negedge monitor pops
// and compares on every accepted handshake.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        busy;
    logic        align_err;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_ctrl #(
        .ADDR_W      (64),
        .INSTR_W     (32),
        .RESET_PC    (64'h0),
        .WAIT_CYCLES (1),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .busy        (busy),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'd0:   return 32'h8B1F03E5;
            64'd16:  return 32'hF84000A4;
            64'd32:  return 32'h8B040086;
            64'd48:  return 32'hF80010A6;
            default: return 32'h0;
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ent(input logic [63:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
    endtask

    // Monitor: every accepted, non-void handshake must match the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h, required no entry", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("head_pc", out_pc, mon_e.pc);
                check("head_instr", {32'h0, out_instr}, {32'h0, mon_e.instr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;

        // Reset values and first-fetch latency / throughput.
        do_reset();
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_align", {63'h0, align_err}, 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", {32'h0, out_instr}, 64'h0);
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p <= 16; p += 4) expect_ent(64'(p));
        tick();
        check("lat_c1_valid", {63'h0, out_valid}, 64'h0);
        check("lat_c1_busy", {63'h0, busy}, 64'h1);
        tick();
        check("lat_c2_valid", {63'h0, out_valid}, 64'h0);
        tick();
        check("lat_c3_valid", {63'h0, out_valid}, 64'h1);
        tick();
        check("gap_valid", {63'h0, out_valid}, 64'h0);
        check("hold_out_pc", out_pc, 64'h0);
        check("hold_out_instr", {32'h0, out_instr}, 64'h8B1F03E5);
        tick();
        check("second_valid", {63'h0, out_valid}, 64'h1);
        drain(40);

        // Back-pressure into S_HOLD, then release.
        do_reset();
        enable = 1'b1;
        for (int p = 0; p <= 12; p += 4) expect_ent(64'(p));
        repeat (7) tick();
        check("hold_addr", imem_addr, 64'd8);
        check("hold_busy", {63'h0, busy}, 64'h1);
        repeat (2) tick();
        check("hold_addr_frozen", imem_addr, 64'd8);
        check("hold_head_pc", out_pc, 64'd0);
        out_ready = 1'b1;
        tick();
        check("pop_push_head", out_pc, 64'd4);
        check("pop_push_addr", imem_addr, 64'd12);
        drain(40);

        // Redirect with two entries buffered; the handshake in that cycle is void.
        do_reset();
        enable = 1'b1;
        repeat (7) tick();
        expect_ent(64'd32);
        expect_ent(64'd36);
        redirect    = 1'b1;
        redirect_pc = 64'd32;
        out_ready   = 1'b1;
        tick();
        redirect = 1'b0;
        check("redir_flush_valid", {63'h0, out_valid}, 64'h0);
        check("redir_addr", imem_addr, 64'd32);
        check("redir_align", {63'h0, align_err}, 64'h0);
        drain(40);

        // Misaligned redirect target.
        expect_ent(64'd48);
        redirect    = 1'b1;
        redirect_pc = 64'h31;
        tick();
        redirect = 1'b0;
        check("mis_align_set", {63'h0, align_err}, 64'h1);
        check("mis_addr", imem_addr, 64'd48);
        check("mis_flush_valid", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b1;
        drain(40);
        repeat (3) tick();
        check("mis_align_sticky", {63'h0, align_err}, 64'h1);

        // pc wraps past the top of the address space.
        expect_ent(64'hFFFF_FFFF_FFFF_FFFC);
        expect_ent(64'h0);
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        out_ready = 1'b1;
        drain(40);
        check("wrap_align_sticky", {63'h0, align_err}, 64'h1);

        // enable dropped mid-settle, and again at the start of a settle.
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p <= 12; p += 4) expect_ent(64'(p));
        repeat (4) tick();
        enable = 1'b0;
        repeat (3) tick();
        check("freeze_addr", imem_addr, 64'd4);
        check("freeze_busy", {63'h0, busy}, 64'h1);
        enable = 1'b1;
        tick();
        check("resume_addr", imem_addr, 64'd8);
        enable = 1'b0;
        tick();
        check("park_busy", {63'h0, busy}, 64'h0);
        check("park_addr", imem_addr, 64'd8);
        enable = 1'b1;
        drain(40);

        // Asynchronous reset with one entry buffered.
        do_reset();
        enable = 1'b1;
        repeat (4) tick();
        check("pre_rst_valid", {63'h0, out_valid}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {63'h0, out_valid}, 64'h0);
        check("async_rst_addr", imem_addr, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        tick();
        reset  = 1'b0;
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
